mlp_load_sequencer: RTL and testbench

- Upstream feeder for the MLP accelerator top.
- Accepts a flat valid/ready stream of signed 16-bit elements from the host FIFO and packs element pairs into 32-bit load beats.
- Generates the accelerator load sideband: load_en, load_type, input row number, layer number and weight number.
- Sequence: layer 0 interleaves 8 input beats and 8 weight beats per row; layers 1..7 carry 8 weight beats per row only.

---
 rtl/mlp_pkg.sv | 28 ++
 rtl/mlp_pair_packer.sv | 56 +++++
 rtl/mlp_load_sequencer.sv | 128 ++++++++++++
 tb/tb_mlp_load_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and sizing for the MLP load sequencer: FSM states, matrix
// dimensions and the sideband that travels with every load beat.
package mlp_pkg;

  localparam int N_ROWS   = 16;
  localparam int N_LAYERS = 8;
  localparam int ELEM_W   = 16;
  localparam int PAIRS    = N_ROWS / 2;

  localparam int ROW_W   = $clog2(N_ROWS);
  localparam int LAYER_W = $clog2(N_LAYERS);
  localparam int PAIR_W  = $clog2(PAIRS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN,
    ST_W,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic               ltype;
    logic [ROW_W-1:0]   row;
    logic [LAYER_W-1:0] layer;
    logic [PAIR_W-1:0]  wnum;
  } beat_side_t;

endpackage

// File: rtl/mlp_pair_packer.sv
// Packs consecutive host elements into {second, first} load beats; the beat
// is registered so it appears one cycle after the second element is accepted.
module mlp_pair_packer
  import mlp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                accept_i,
  input  logic [ELEM_W-1:0]   data_i,
  output logic                pair_done_o,
  output logic                load_en_o,
  output logic [2*ELEM_W-1:0] payload_o
);

  logic                phase_q, phase_d;
  logic [ELEM_W-1:0]   low_q, low_d;
  logic [2*ELEM_W-1:0] payload_q, payload_d;
  logic                en_q, en_d;

  assign pair_done_o = accept_i && phase_q;
  assign load_en_o   = en_q;
  assign payload_o   = payload_q;

  // phase and low half survive any number of idle cycles between halves
  always_comb begin
    phase_d   = phase_q;
    low_d     = low_q;
    payload_d = payload_q;
    en_d      = 1'b0;
    if (accept_i) begin
      if (!phase_q) begin
        low_d   = data_i;
        phase_d = 1'b1;
      end else begin
        payload_d = {data_i, low_q};
        en_d      = 1'b1;
        phase_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      low_q     <= '0;
      payload_q <= '0;
      en_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      low_q     <= low_d;
      payload_q <= payload_d;
      en_q      <= en_d;
    end
  end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Feeds the MLP accelerator: layer 0 alternates input and weight rows, later
// layers carry weight rows only; sideband is captured alongside each beat.
module mlp_load_sequencer
  import mlp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                s_valid_i,
  input  logic [ELEM_W-1:0]   s_data_i,
  output logic                s_ready_o,
  output logic                load_en_o,
  output logic [2*ELEM_W-1:0] load_payload_o,
  output logic                load_type_o,
  output logic [ROW_W-1:0]    input_load_number_o,
  output logic [LAYER_W-1:0]  layer_number_o,
  output logic [PAIR_W-1:0]   weight_number_o,
  output logic                busy_o,
  output logic                done_o
);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [PAIR_W-1:0]  pair_q, pair_d;
  logic               last_q, last_d;
  beat_side_t         side_q, side_d;
  logic               accept;
  logic               pair_done;

  // last_q covers the cycle where the final beat is on the bus: still busy,
  // but no further elements may be taken
  assign busy_o    = (state_q == ST_IN) || (state_q == ST_W);
  assign s_ready_o = busy_o && !last_q;
  assign accept    = s_valid_i && s_ready_o;
  assign done_o    = (state_q == ST_DONE);

  assign load_type_o         = side_q.ltype;
  assign input_load_number_o = side_q.row;
  assign layer_number_o      = side_q.layer;
  assign weight_number_o     = side_q.wnum;

  mlp_pair_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (accept),
    .data_i      (s_data_i),
    .pair_done_o (pair_done),
    .load_en_o   (load_en_o),
    .payload_o   (load_payload_o)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    layer_d = layer_q;
    pair_d  = pair_q;
    last_d  = last_q;
    side_d  = side_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_IN;
          row_d   = '0;
          layer_d = '0;
          pair_d  = '0;
          last_d  = 1'b0;
        end
      end
      ST_IN: begin
        if (pair_done) begin
          side_d = '{ltype: 1'b1, row: row_q, layer: layer_q, wnum: '0};
          if (pair_q == PAIR_W'(PAIRS - 1)) begin
            pair_d  = '0;
            state_d = ST_W;
          end else begin
            pair_d = pair_q + PAIR_W'(1);
          end
        end
      end
      ST_W: begin
        if (last_q) begin
          state_d = ST_DONE;
        end else if (pair_done) begin
          side_d = '{ltype: 1'b0, row: row_q, layer: layer_q, wnum: pair_q};
          if (pair_q != PAIR_W'(PAIRS - 1)) begin
            pair_d = pair_q + PAIR_W'(1);
          end else begin
            pair_d = '0;
            if (row_q != ROW_W'(N_ROWS - 1)) begin
              row_d = row_q + ROW_W'(1);
              if (layer_q == '0) state_d = ST_IN;
            end else if (layer_q == LAYER_W'(N_LAYERS - 1)) begin
              last_d = 1'b1;
            end else begin
              row_d   = '0;
              layer_d = layer_q + LAYER_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      layer_q <= '0;
      pair_q  <= '0;
      last_q  <= 1'b0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      layer_q <= layer_d;
      pair_q  <= pair_d;
      last_q  <= last_d;
      side_q  <= side_d;
    end
  end

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Bench for mlp_load_sequencer: a whole-sequence beat list built from the
// load order, checked every cycle, plus literal expectations on chosen beats.
module tb_mlp_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic [15:0] s_data_i = '0;
  logic        s_ready_o;
  logic        load_en_o;
  logic [31:0] load_payload_o;
  logic        load_type_o;
  logic [3:0]  input_load_number_o;
  logic [2:0]  layer_number_o;
  logic [2:0]  weight_number_o;
  logic        busy_o;
  logic        done_o;

  mlp_load_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .s_valid_i           (s_valid_i),
    .s_data_i            (s_data_i),
    .s_ready_o           (s_ready_o),
    .load_en_o           (load_en_o),
    .load_payload_o      (load_payload_o),
    .load_type_o         (load_type_o),
    .input_load_number_o (input_load_number_o),
    .layer_number_o      (layer_number_o),
    .weight_number_o     (weight_number_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] pl;
    logic        t;
    logic [3:0]  row;
    logic [2:0]  layer;
    logic [2:0]  wnum;
  } beat_t;

  int    n_pass = 0;
  int    n_total = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  int    got_cyc[$];
  int    acc_cyc[$];
  beat_t last_exp = '0;
  logic [15:0] elem [2304];
  bit    sb_en = 1'b0;
  bit    done_pending = 1'b0;
  int    done_cnt = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic beat_t dut_beat();
    return {load_payload_o, load_type_o, input_load_number_o, layer_number_o, weight_number_o};
  endfunction

  // Load order: layer 0 rows are 8 input beats then 8 weight beats, later
  // layers 8 weight beats per row; payload k is {elem[2k+1], elem[2k]}.
  function automatic void build_model();
    int k;
    k = 0;
    exp_q.delete();
    for (int layer = 0; layer < 8; layer++) begin
      for (int row = 0; row < 16; row++) begin
        if (layer == 0) begin
          for (int p = 0; p < 8; p++) begin
            exp_q.push_back({elem[2*k+1], elem[2*k], 1'b1, 4'(row), 3'd0, 3'd0});
            k++;
          end
        end
        for (int p = 0; p < 8; p++) begin
          exp_q.push_back({elem[2*k+1], elem[2*k], 1'b0, 4'(row), 3'(layer), 3'(p)});
          k++;
        end
      end
    end
  endfunction

  // Every cycle: a beat must be the next one in order; otherwise the bus
  // holds the previous beat. done is due exactly one cycle after the last.
  always @(negedge clk) begin
    bit    want_done;
    beat_t act;
    if (sb_en) begin
      want_done    = done_pending;
      done_pending = 1'b0;
      act          = dut_beat();
      if (load_en_o) begin
        if (exp_q.size() == 0) begin
          check_output("extra_beat", 64'(act), 64'(0));
        end else begin
          last_exp = exp_q.pop_front();
          check_output("beat", 64'(act), 64'(last_exp));
          got_q.push_back(act);
          got_cyc.push_back(cyc);
          if (exp_q.size() == 0) done_pending = 1'b1;
        end
      end else begin
        check_output("hold", 64'(act), 64'(last_exp));
      end
      check_output("done", 64'(done_o), 64'(want_done));
      if (want_done) check_output("busy_at_done", 64'(busy_o), 64'(0));
    end
    if (done_o) done_cnt++;
  end

  task automatic apply_stimulus(input logic [15:0] d);
    bit   ok;
    logic r;
    int   c;
    ok = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      r = s_ready_o;
      c = cyc;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        acc_cyc.push_back(c);
      end
    end
    #1 s_valid_i = 1'b0;
    check_output("accept", 64'(ok), 64'(1));
  endtask

  task automatic start_seq();
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_load_en"}, 64'(load_en_o), 64'(0));
    check_output({tag, "_payload"}, 64'(load_payload_o), 64'(0));
    check_output({tag, "_sideband"}, 64'({load_type_o, input_load_number_o, layer_number_o, weight_number_o}), 64'(0));
    check_output({tag, "_busy"}, 64'(busy_o), 64'(0));
    check_output({tag, "_done"}, 64'(done_o), 64'(0));
    check_output({tag, "_ready"}, 64'(s_ready_o), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gap;
    int n_type1;
    int idx;

    // reset held for three cycles, then elements offered while idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 16'h5555;
    repeat (3) begin
      @(negedge clk);
      check_output("idle_ready", 64'(s_ready_o), 64'(0));
      check_output("idle_load_en", 64'(load_en_o), 64'(0));
    end
    @(posedge clk);
    #1 s_valid_i = 1'b0;

    // full sequence: counting pattern first, a bubble between 0x1111 and
    // 0x2222, a stray start in layer 2, random gaps elsewhere
    for (int i = 0; i < 2304; i++) elem[i] = (i < 32) ? 16'(i + 1) : 16'($urandom);
    elem[32] = 16'h1111;
    elem[33] = 16'h2222;
    build_model();
    sb_en = 1'b1;
    start_seq();
    for (int i = 0; i < 2304; i++) begin
      if (i < 33)       gap = 0;
      else if (i == 33) gap = 3;
      else              gap = $urandom_range(0, 2);
      if (i == 800) begin
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
      end
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      apply_stimulus(elem[i]);
    end
    for (int t = 0; t < 20 && done_cnt == 0; t++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;

    check_output("done_pulses", 64'(done_cnt), 64'(1));
    check_output("beat_count", 64'(got_q.size()), 64'(1152));
    check_output("beats_left", 64'(exp_q.size()), 64'(0));
    n_type1 = 0;
    foreach (got_q[k]) if (got_q[k].t) n_type1++;
    check_output("type1_count", 64'(n_type1), 64'(128));
    check_output("last_sideband", 64'({got_q[$].t, got_q[$].row, got_q[$].layer, got_q[$].wnum}),
                 64'({1'b0, 4'd15, 3'd7, 3'd7}));
    check_output("beat1", 64'(got_q[0]), 64'({32'h00020001, 1'b1, 4'd0, 3'd0, 3'd0}));
    check_output("beat1_latency", 64'(got_cyc[0]), 64'(acc_cyc[1] + 1));
    check_output("beat8", 64'({got_q[7].pl, got_q[7].t}), 64'({32'h0010000F, 1'b1}));
    check_output("beat9", 64'({got_q[8].pl, got_q[8].t, got_q[8].wnum}), 64'({32'h00120011, 1'b0, 3'd0}));
    check_output("beat16", 64'({got_q[15].pl, got_q[15].t, got_q[15].wnum}), 64'({32'h0020001F, 1'b0, 3'd7}));
    check_output("beat17", 64'(got_q[16]), 64'({32'h22221111, 1'b1, 4'd1, 3'd0, 3'd0}));
    check_output("bubble_accept_gap", 64'(acc_cyc[33] - acc_cyc[32]), 64'(4));
    check_output("bubble_beat_gap", 64'(got_cyc[16] - got_cyc[15]), 64'(5));

    s_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_output("after_done_ready", 64'(s_ready_o), 64'(0));
    end
    @(posedge clk);
    #1 s_valid_i = 1'b0;

    // second run cut short by reset at layer 3 row 5 with a half pair held
    for (int i = 0; i < 2304; i++) elem[i] = 16'($urandom);
    build_model();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
    start_seq();
    for (int i = 0; i < 1105; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      apply_stimulus(elem[i]);
    end
    check_output("pre_reset_beats", 64'(got_q.size()), 64'(552));
    rst_n = 1'b0;
    sb_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    exp_q.delete();
    last_exp     = '0;
    done_pending = 1'b0;
    elem[0] = 16'hAAAA;
    elem[1] = 16'hBBBB;
    build_model();
    idx   = got_q.size();
    sb_en = 1'b1;
    start_seq();
    apply_stimulus(16'hAAAA);
    apply_stimulus(16'hBBBB);
    repeat (3) @(posedge clk);
    #1;
    check_output("post_reset_beat_seen", 64'(got_q.size() > idx), 64'(1));
    check_output("post_reset_beat", 64'(got_q[idx]), 64'({32'hBBBBAAAA, 1'b1, 4'd0, 3'd0, 3'd0}));
    check_output("done_pulses_final", 64'(done_cnt), 64'(1));

    sb_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
